// File: rtl/tx_mac_control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tx_mac_control_pkg
// Purpose  : Shared constants, the transmit FSM state type and the byte-wide
//            CRC-32 step function used by both the transmit and receive MAC.
// Contents : DATA_WIDTH, PREAMBLE_BYTE, SFD_BYTE, CRC32_CONSTANT, CRC32_INIT,
//            tx_state_t, crc32_next()
// Revision : 1.0 - initial release
// ============================================================================
package tx_mac_control_pkg;

  localparam int          DATA_WIDTH     = 8;
  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;
  // Reflected IEEE 802.3 generator polynomial.
  localparam logic [31:0] CRC32_CONSTANT = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_DRAIN    = 3'd6,
    ST_IFG      = 3'd7
  } tx_state_t;

  // One byte of the LSB-first CRC-32; the byte enters bit 0 first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_CONSTANT) : (c >> 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tx_mac_control_crc32.sv
`default_nettype none
// ============================================================================
// Module   : tx_crc32
// Purpose  : Byte-wide running CRC-32 register with the complemented value
//            presented as the frame check sequence.
// Ports    : switch_clk, switch_rst_n - clock, async active-low reset
//            i_init   - reload the register with all ones (wins over enable)
//            i_enable - fold i_data into the register
//            i_data   - byte to fold
//            o_fcs    - ~CRC, transmitted least significant byte first
// Revision : 1.0 - initial release
// ============================================================================
module tx_crc32
  import tx_mac_control_pkg::*;
(
  input  logic                  switch_clk,
  input  logic                  switch_rst_n,
  input  logic                  i_init,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [31:0]           o_fcs
);

  logic [31:0] r_crc;

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      r_crc <= CRC32_INIT;
    end else if (i_init) begin
      r_crc <= CRC32_INIT;
    end else if (i_enable) begin
      r_crc <= crc32_next(r_crc, i_data);
    end
  end

  assign o_fcs = ~r_crc;

endmodule
`default_nettype wire

// File: rtl/tx_mac_control.sv
`default_nettype none
// ============================================================================
// Module   : tx_mac_control
// Purpose  : Transmit MAC framer for one switch egress port. Takes DA..payload
//            bytes from egress memory and emits a GMII stream: preamble, SFD,
//            data, optional minimum-size padding, FCS and inter-frame gap.
// Config   : TX_PAD_EN - when defined, frames shorter than MIN_DATA_BYTES are
//            zero-padded before the FCS; when undefined they go out unpadded.
// Ports    : switch_clk/switch_rst_n  clock, async active-low reset
//            frame_*_i / frame_ready_o  byte stream from egress memory
//            gmii_tx_*_o                registered GMII transmit outputs
//            tx_frame_count_o           frames started (wraps)
//            tx_error_count_o           frames poisoned or aborted (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module tx_mac_control
  import tx_mac_control_pkg::*;
#(
  parameter int IFG_BYTES      = 12,
  parameter int MIN_DATA_BYTES = 60
) (
  input  logic                  switch_clk,
  input  logic                  switch_rst_n,
  input  logic [DATA_WIDTH-1:0] frame_data_i,
  input  logic                  frame_valid_i,
  input  logic                  frame_sof_i,
  input  logic                  frame_eof_i,
  input  logic                  frame_error_i,
  output logic                  frame_ready_o,
  output logic [DATA_WIDTH-1:0] gmii_tx_data_o,
  output logic                  gmii_tx_en_o,
  output logic                  gmii_tx_er_o,
  output logic [31:0]           tx_frame_count_o,
  output logic [31:0]           tx_error_count_o
);

`ifdef TX_PAD_EN
  localparam logic c_PAD_EN = 1'b1;
`else
  localparam logic c_PAD_EN = 1'b0;
`endif
  localparam logic [10:0] c_MIN      = 11'(MIN_DATA_BYTES);
  localparam logic [7:0]  c_IFG_LAST = 8'(IFG_BYTES - 1);

  tx_state_t       r_state;
  logic [10:0]     r_byte_cnt;
  logic [2:0]      r_pre_cnt;
  logic [1:0]      r_fcs_idx;
  logic [7:0]      r_ifg_cnt;
  logic            r_poison;

  logic [10:0]     w_cnt_inc;
  logic            w_short;
  logic            w_data_ok;
  logic            w_in_pad;
  logic            w_crc_init;
  logic            w_crc_en;
  logic [DATA_WIDTH-1:0] w_crc_data;
  logic [31:0]     w_fcs;

  // Byte counter saturates rather than wrapping on jumbo frames.
  assign w_cnt_inc = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
  assign w_short   = c_PAD_EN && (w_cnt_inc < c_MIN);
  // The first DATA byte is the sof byte left waiting in IDLE; any later sof
  // means the memory started a new frame before finishing this one.
  assign w_data_ok = frame_valid_i && ((r_byte_cnt == 11'd0) || !frame_sof_i);
  assign w_in_pad  = c_PAD_EN && (r_state == ST_PAD);

  assign w_crc_init = (r_state == ST_IDLE) && frame_valid_i && frame_sof_i;
  assign w_crc_en   = ((r_state == ST_DATA) && w_data_ok) || w_in_pad;
  assign w_crc_data = w_in_pad ? '0 : frame_data_i;

  // IDLE swallows stray non-sof bytes so a broken stream resynchronises.
  always_comb begin
    frame_ready_o = 1'b0;
    case (r_state)
      ST_DATA, ST_DRAIN: frame_ready_o = 1'b1;
      ST_IDLE:           frame_ready_o = !frame_sof_i;
      default:           frame_ready_o = 1'b0;
    endcase
  end

  tx_crc32 u_crc (
    .switch_clk   (switch_clk),
    .switch_rst_n (switch_rst_n),
    .i_init       (w_crc_init),
    .i_enable     (w_crc_en),
    .i_data       (w_crc_data),
    .o_fcs        (w_fcs)
  );

  // Each state computes the byte that appears on the wire in the next cycle.
  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      r_state          <= ST_IDLE;
      r_byte_cnt       <= '0;
      r_pre_cnt        <= '0;
      r_fcs_idx        <= '0;
      r_ifg_cnt        <= '0;
      r_poison         <= 1'b0;
      gmii_tx_data_o   <= '0;
      gmii_tx_en_o     <= 1'b0;
      gmii_tx_er_o     <= 1'b0;
      tx_frame_count_o <= '0;
      tx_error_count_o <= '0;
    end else begin
      gmii_tx_data_o <= '0;
      gmii_tx_en_o   <= 1'b0;
      gmii_tx_er_o   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (frame_valid_i && frame_sof_i) begin
            r_state          <= ST_PREAMBLE;
            tx_frame_count_o <= tx_frame_count_o + 32'd1;
            r_byte_cnt       <= '0;
            r_pre_cnt        <= 3'd1;
            r_poison         <= 1'b0;
            gmii_tx_en_o     <= 1'b1;
            gmii_tx_data_o   <= PREAMBLE_BYTE;
          end
        end
        ST_PREAMBLE: begin
          gmii_tx_en_o   <= 1'b1;
          gmii_tx_data_o <= PREAMBLE_BYTE;
          r_pre_cnt      <= r_pre_cnt + 3'd1;
          if (r_pre_cnt == 3'd6) r_state <= ST_SFD;
        end
        ST_SFD: begin
          gmii_tx_en_o   <= 1'b1;
          gmii_tx_data_o <= SFD_BYTE;
          r_state        <= ST_DATA;
        end
        ST_DATA: begin
          gmii_tx_en_o <= 1'b1;
          if (w_data_ok) begin
            gmii_tx_data_o <= frame_data_i;
            r_byte_cnt     <= w_cnt_inc;
            if (frame_eof_i) begin
              r_poison  <= frame_error_i;
              r_fcs_idx <= '0;
              r_state   <= w_short ? ST_PAD : ST_FCS;
            end
          end else begin
            // Underrun: one error byte ends the frame on the wire.
            gmii_tx_er_o     <= 1'b1;
            tx_error_count_o <= tx_error_count_o + 32'd1;
            if (frame_valid_i && frame_eof_i) begin
              r_state   <= ST_IFG;
              r_ifg_cnt <= '0;
            end else begin
              r_state <= ST_DRAIN;
            end
          end
        end
`ifdef TX_PAD_EN
        ST_PAD: begin
          gmii_tx_en_o <= 1'b1;
          r_byte_cnt   <= w_cnt_inc;
          if (!w_short) begin
            r_state   <= ST_FCS;
            r_fcs_idx <= '0;
          end
        end
`endif
        ST_FCS: begin
          gmii_tx_en_o   <= 1'b1;
          gmii_tx_data_o <= w_fcs[{r_fcs_idx, 3'b000} +: DATA_WIDTH];
          r_fcs_idx      <= r_fcs_idx + 2'd1;
          if ((r_fcs_idx == 2'd0) && r_poison) begin
            gmii_tx_er_o     <= 1'b1;
            tx_error_count_o <= tx_error_count_o + 32'd1;
          end
          if (r_fcs_idx == 2'd3) begin
            r_state   <= ST_IFG;
            r_ifg_cnt <= '0;
          end
        end
        ST_DRAIN: begin
          if (frame_valid_i && frame_eof_i) begin
            r_state   <= ST_IFG;
            r_ifg_cnt <= '0;
          end
        end
        ST_IFG: begin
          if (r_ifg_cnt == c_IFG_LAST) begin
            r_state <= ST_IDLE;
          end else begin
            r_ifg_cnt <= r_ifg_cnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tx_mac_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_tx_mac_control
// Purpose  : Self-checking bench for tx_mac_control. Frames are built from
//            random bytes; the expected wire image (preamble, SFD, data,
//            padding when TX_PAD_EN is defined, bit-serial CRC-32 FCS) is
//            produced by a reference model and compared with the captured
//            tx_en-high runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_mac_control;

  logic        switch_clk = 1'b0;
  logic        switch_rst_n = 1'b0;
  logic [7:0]  frame_data_i = '0;
  logic        frame_valid_i = 1'b0;
  logic        frame_sof_i = 1'b0;
  logic        frame_eof_i = 1'b0;
  logic        frame_error_i = 1'b0;
  logic        frame_ready_o;
  logic [7:0]  gmii_tx_data_o;
  logic        gmii_tx_en_o;
  logic        gmii_tx_er_o;
  logic [31:0] tx_frame_count_o;
  logic [31:0] tx_error_count_o;

  tx_mac_control dut (
    .switch_clk       (switch_clk),
    .switch_rst_n     (switch_rst_n),
    .frame_data_i     (frame_data_i),
    .frame_valid_i    (frame_valid_i),
    .frame_sof_i      (frame_sof_i),
    .frame_eof_i      (frame_eof_i),
    .frame_error_i    (frame_error_i),
    .frame_ready_o    (frame_ready_o),
    .gmii_tx_data_o   (gmii_tx_data_o),
    .gmii_tx_en_o     (gmii_tx_en_o),
    .gmii_tx_er_o     (gmii_tx_er_o),
    .tx_frame_count_o (tx_frame_count_o),
    .tx_error_count_o (tx_error_count_o)
  );

  always #5 switch_clk = ~switch_clk;

  int cyc = 0;
  always @(posedge switch_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;
  int exp_errs   = 0;
  int sof_cyc  = 0;

  // Wire capture: {en, er, data} each cycle, sampled on the falling edge.
  bit         cap_on = 1'b0;
  logic [9:0] cap[$];
  int         cap_cyc[$];
  always @(negedge switch_clk) begin
    if (cap_on) begin
      cap.push_back({gmii_tx_en_o, gmii_tx_er_o, gmii_tx_data_o});
      cap_cyc.push_back(cyc);
    end
  end

  logic [8:0] run_q[$];
  logic [8:0] exp_q[$];
  int         run_start;
  int         run_gap;

  // ---------------- reference model ----------------
  function automatic logic [31:0] sw_fcs(input logic [7:0] b[$]);
    logic [31:0] crc;
    logic        fb;
    crc = 32'hFFFFFFFF;
    foreach (b[i]) begin
      for (int k = 0; k < 8; k++) begin
        fb  = crc[0] ^ b[i][k];
        crc = crc >> 1;
        if (fb) crc = crc ^ 32'hEDB88320;
      end
    end
    return ~crc;
  endfunction

  task automatic build_expected(input logic [7:0] pl[$], input bit err);
    logic [7:0]  body[$];
    logic [31:0] f;
    body = pl;
`ifdef TX_PAD_EN
    while (body.size() < 60) body.push_back(8'h00);
`endif
    f = sw_fcs(body);
    exp_q = {};
    repeat (7) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    foreach (body[i]) exp_q.push_back({1'b0, body[i]});
    for (int k = 0; k < 4; k++) exp_q.push_back({(err && (k == 0)), f[8*k +: 8]});
  endtask

  // k-th contiguous tx_en-high run of the capture, plus idle gap before it.
  task automatic extract_run(input int k);
    int r = -1;
    int prev_end = -1;
    bit in_run = 1'b0;
    run_q = {};
    run_start = -1;
    run_gap = -1;
    for (int i = 0; i < cap.size(); i++) begin
      if (cap[i][9] && !in_run) begin
        in_run = 1'b1;
        r++;
        if (r == k) begin
          run_start = i;
          run_gap = (prev_end < 0) ? -1 : (i - prev_end - 1);
        end
      end else if (!cap[i][9] && in_run) begin
        in_run = 1'b0;
        prev_end = i - 1;
      end
      if (cap[i][9] && (r == k)) run_q.push_back(cap[i][8:0]);
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (run_q.size() > exp_q.size()) ? run_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i >= run_q.size() || i >= exp_q.size()) return i;
      if (run_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic int count_er();
    int n = 0;
    foreach (cap[i]) if (cap[i][9] && cap[i][8]) n++;
    return n;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    frame_valid_i = 1'b0;
    frame_sof_i   = 1'b0;
    frame_eof_i   = 1'b0;
    frame_error_i = 1'b0;
    frame_data_i  = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge switch_clk);
    #1;
  endtask

  task automatic start_capture();
    cap = {};
    cap_cyc = {};
    cap_on = 1'b1;
  endtask

  task automatic rand_payload(input int len, output logic [7:0] pl[$]);
    pl = {};
    for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
  endtask

  // Drives one frame; drop_at inserts one valid-low cycle before that byte,
  // stop_after > 0 abandons the frame after that many cycles.
  task automatic drive_frame(input logic [7:0] pl[$], input bit err,
                             input int drop_at, input int stop_after);
    int i = 0;
    int cycles = 0;
    bit dropped = 1'b0;
    bit acc;
    sof_cyc = cyc;
    while (i < pl.size()) begin
      if ((i == drop_at) && !dropped) begin
        dropped = 1'b1;
        idle_inputs();
        @(posedge switch_clk);
        #1;
      end else begin
        frame_valid_i = 1'b1;
        frame_data_i  = pl[i];
        frame_sof_i   = (i == 0);
        frame_eof_i   = (i == pl.size() - 1);
        frame_error_i = err && (i == pl.size() - 1);
        @(negedge switch_clk);
        acc = frame_ready_o;
        @(posedge switch_clk);
        #1;
        if (acc) i++;
      end
      cycles++;
      if ((stop_after > 0) && (cycles >= stop_after)) return;
      if (cycles > 4000) begin
        n_checks++;
        n_fail++;
        $display("FAIL drive_timeout: accepted %0d of %0d bytes, required all", i, pl.size());
        return;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if (gmii_tx_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b, expected 0", gmii_tx_en_o); end
    n_checks++;
    if (gmii_tx_er_o !== 1'b0) begin n_fail++; $display("FAIL reset_er: got %b, expected 0", gmii_tx_er_o); end
    n_checks++;
    if (gmii_tx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, expected 00", gmii_tx_data_o); end
    n_checks++;
    if (tx_frame_count_o !== 32'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d, expected 0", tx_frame_count_o); end
    n_checks++;
    if (tx_error_count_o !== 32'd0) begin n_fail++; $display("FAIL reset_error_count: got %0d, expected 0", tx_error_count_o); end
    n_checks++;
    if (frame_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_idle: got %b, expected 1", frame_ready_o); end
  endtask

  task automatic test_frame_64();
    logic [7:0] pl[$];
    int d;
    int lat;
    pl = {};
    repeat (60) pl.push_back(8'hA5);
    start_capture();
    drive_frame(pl, 1'b0, -1, 0);
    idle_inputs();
    wait_cycles(90);
    exp_frames++;
    build_expected(pl, 1'b0);
    extract_run(0);
    d = first_diff();
    n_checks++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL frame64_stream: first difference at byte %0d, got %0d bytes, expected %0d bytes", d, run_q.size(), exp_q.size());
    end
    n_checks++;
    if (run_q.size() !== 72) begin n_fail++; $display("FAIL frame64_en_length: got %0d cycles, expected 72", run_q.size()); end
    lat = (run_start >= 0) ? (cap_cyc[run_start] - sof_cyc) : -1;
    n_checks++;
    if (lat !== 1) begin n_fail++; $display("FAIL frame64_latency: got %0d cycles, expected 1", lat); end
    n_checks++;
    if (count_er() !== 0) begin n_fail++; $display("FAIL frame64_er: got %0d er bytes, expected 0", count_er()); end
    n_checks++;
    if (tx_frame_count_o !== 32'(exp_frames)) begin n_fail++; $display("FAIL frame64_count: got %0d, expected %0d", tx_frame_count_o, exp_frames); end
  endtask

  task automatic test_short_frame();
    logic [7:0] pl[$];
    int d;
    int exp_len;
`ifdef TX_PAD_EN
    exp_len = 8 + 60 + 4;
`else
    exp_len = 8 + 14 + 4;
`endif
    rand_payload(14, pl);
    start_capture();
    drive_frame(pl, 1'b0, -1, 0);
    idle_inputs();
    wait_cycles(90);
    exp_frames++;
    build_expected(pl, 1'b0);
    extract_run(0);
    d = first_diff();
    n_checks++;
    if (d !== -1) begin
      n_fail++;
      $display("FAIL short_stream: first difference at byte %0d, got %0d bytes, expected %0d bytes", d, run_q.size(), exp_q.size());
    end
    n_checks++;
    if (run_q.size() !== exp_len) begin n_fail++; $display("FAIL short_length: got %0d, expected %0d", run_q.size(), exp_len); end
  endtask

  task automatic test_random_frames();
    logic [7:0] pl[$];
    int d;
    int len;
    for (int f = 0; f < 6; f++) begin
      len = (f == 0) ? 1 : int'($urandom_range(2, 100));
      rand_payload(len, pl);
      start_capture();
      drive_frame(pl, 1'b0, -1, 0);
      idle_inputs();
      wait_cycles(90);
      exp_frames++;
      build_expected(pl, 1'b0);
      extract_run(0);
      d = first_diff();
      n_checks++;
      if (d !== -1) begin
        n_fail++;
        $display("FAIL random_stream[%0d] len=%0d: first difference at byte %0d, got %0d bytes, expected %0d bytes", f, len, d, run_q.size(), exp_q.size());
      end
      n_checks++;
      if (tx_frame_count_o !== 32'(exp_frames)) begin n_fail++; $display("FAIL random_count[%0d]: got %0d, expected %0d", f, tx_frame_count_o, exp_frames); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa[$];
    logic [7:0] pb[$];
    int d;
    rand_payload(int'($urandom_range(60, 80)), pa);
    rand_payload(int'($urandom_range(60, 80)), pb);
    start_capture();
    drive_frame(pa, 1'b0, -1, 0);
    drive_frame(pb, 1'b0, -1, 0);
    idle_inputs();
    wait_cycles(60);
    exp_frames += 2;
    build_expected(pa, 1'b0);
    extract_run(0);
    d = first_diff();
    n_checks++;
    if (d !== -1) begin n_fail++; $display("FAIL b2b_first_stream: first difference at byte %0d, got %0d bytes, expected %0d", d, run_q.size(), exp_q.size()); end
    build_expected(pb, 1'b0);
    extract_run(1);
    d = first_diff();
    n_checks++;
    if (d !== -1) begin n_fail++; $display("FAIL b2b_second_stream: first difference at byte %0d, got %0d bytes, expected %0d", d, run_q.size(), exp_q.size()); end
    n_checks++;
    if (run_gap !== 12) begin n_fail++; $display("FAIL b2b_ifg: got %0d idle cycles, expected 12", run_gap); end
    n_checks++;
    if (tx_frame_count_o !== 32'(exp_frames)) begin n_fail++; $display("FAIL b2b_count: got %0d, expected %0d", tx_frame_count_o, exp_frames); end
  endtask

  task automatic test_error_eof();
    logic [7:0] pl[$];
    int d;
    rand_payload(64, pl);
    start_capture();
    drive_frame(pl, 1'b1, -1, 0);
    idle_inputs();
    wait_cycles(40);
    exp_frames++;
    exp_errs++;
    build_expected(pl, 1'b1);
    extract_run(0);
    d = first_diff();
    n_checks++;
    if (d !== -1) begin n_fail++; $display("FAIL poison_stream: first difference at byte %0d, got %0d bytes, expected %0d", d, run_q.size(), exp_q.size()); end
    n_checks++;
    if (count_er() !== 1) begin n_fail++; $display("FAIL poison_er_count: got %0d er bytes, expected 1", count_er()); end
    n_checks++;
    if (tx_error_count_o !== 32'(exp_errs)) begin n_fail++; $display("FAIL poison_error_count: got %0d, expected %0d", tx_error_count_o, exp_errs); end
  endtask

  task automatic test_underrun();
    logic [7:0] pl[$];
    int d;
    rand_payload(40, pl);
    start_capture();
    drive_frame(pl, 1'b0, 20, 0);
    idle_inputs();
    wait_cycles(40);
    exp_frames++;
    exp_errs++;
    exp_q = {};
    repeat (7) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, pl[i]});
    exp_q.push_back({1'b1, 8'h00});
    extract_run(0);
    d = first_diff();
    n_checks++;
    if (d !== -1) begin n_fail++; $display("FAIL underrun_stream: first difference at byte %0d, got %0d bytes, expected %0d", d, run_q.size(), exp_q.size()); end
    n_checks++;
    if (tx_error_count_o !== 32'(exp_errs)) begin n_fail++; $display("FAIL underrun_error_count: got %0d, expected %0d", tx_error_count_o, exp_errs); end
    extract_run(1);
    n_checks++;
    if (run_start !== -1) begin n_fail++; $display("FAIL underrun_drain: got a second tx_en run at capture index %0d, expected none", run_start); end
    n_checks++;
    if (tx_frame_count_o !== 32'(exp_frames)) begin n_fail++; $display("FAIL underrun_frame_count: got %0d, expected %0d", tx_frame_count_o, exp_frames); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pl[$];
    int d;
`ifdef TX_PAD_EN
    rand_payload(14, pl);
    drive_frame(pl, 1'b0, -1, 0);
    idle_inputs();
    wait_cycles(5);
`else
    rand_payload(50, pl);
    drive_frame(pl, 1'b0, -1, 30);
`endif
    n_checks++;
    if (gmii_tx_en_o !== 1'b1) begin n_fail++; $display("FAIL midreset_pre_en: got %b, expected 1", gmii_tx_en_o); end
    #2;
    switch_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gmii_tx_en_o, gmii_tx_er_o, gmii_tx_data_o} !== 10'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got en=%b er=%b data=%h, expected all 0", gmii_tx_en_o, gmii_tx_er_o, gmii_tx_data_o);
    end
    idle_inputs();
    wait_cycles(3);
    switch_rst_n = 1'b1;
    wait_cycles(2);
    exp_frames = 0;
    exp_errs = 0;
    n_checks++;
    if ({tx_frame_count_o, tx_error_count_o} !== 64'd0) begin
      n_fail++;
      $display("FAIL midreset_counters: got frames=%0d errors=%0d, expected 0 and 0", tx_frame_count_o, tx_error_count_o);
    end
    rand_payload(64, pl);
    start_capture();
    drive_frame(pl, 1'b0, -1, 0);
    idle_inputs();
    wait_cycles(40);
    exp_frames++;
    build_expected(pl, 1'b0);
    extract_run(0);
    d = first_diff();
    n_checks++;
    if (d !== -1) begin n_fail++; $display("FAIL midreset_next_stream: first difference at byte %0d, got %0d bytes, expected %0d", d, run_q.size(), exp_q.size()); end
    n_checks++;
    if (tx_frame_count_o !== 32'(exp_frames)) begin n_fail++; $display("FAIL midreset_next_count: got %0d, expected %0d", tx_frame_count_o, exp_frames); end
  endtask

  initial begin
    idle_inputs();
    switch_rst_n = 1'b0;
    wait_cycles(3);
    switch_rst_n = 1'b1;
    wait_cycles(2);
    test_reset();
    test_frame_64();
    test_short_frame();
    test_random_frames();
    test_back_to_back();
    test_error_eof();
    test_underrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
